// File: rtl/vvdiv.sv
// vvdiv: per-lane unsigned restoring vector divider, one quotient bit per cycle.
// Define VVDIV_REM_EN to add the remainder output port r.
module vvdiv #(
    parameter int VECTOR_SIZE = 16,
    parameter int INT_SIZE    = 16
) (
    input  logic                                  clock,
    input  logic                                  resetn,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]  a,
    input  logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]  x,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]  q,
`ifdef VVDIV_REM_EN
    output logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]  r,
`endif
    output logic [VECTOR_SIZE-1:0]                dz
);
    localparam int CW = $clog2(INT_SIZE + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [VECTOR_SIZE-1:0][INT_SIZE-1:0] a_reg, x_reg, quo, rem;
    logic [VECTOR_SIZE-1:0][INT_SIZE-1:0] a_nxt, quo_nxt, rem_nxt;
    logic [VECTOR_SIZE-1:0] zero;
    assign in_ready = state == IDLE;
    // A zero divisor always "fits", so the lane naturally yields q=all ones and r=a.
    for (genvar i = 0; i < VECTOR_SIZE; i++) begin : g_lane
        logic [INT_SIZE:0] trial;
        logic ge;
        assign trial      = {rem[i], a_reg[i][INT_SIZE-1]};
        assign ge         = trial >= {1'b0, x_reg[i]};
        assign rem_nxt[i] = ge ? trial[INT_SIZE-1:0] - x_reg[i] : trial[INT_SIZE-1:0];
        assign quo_nxt[i] = {quo[i][INT_SIZE-2:0], ge};
        assign a_nxt[i]   = {a_reg[i][INT_SIZE-2:0], 1'b0};
        assign zero[i]    = x_reg[i] == '0;
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            a_reg     <= '0;
            x_reg     <= '0;
            quo       <= '0;
            rem       <= '0;
            out_valid <= 1'b0;
            q         <= '0;
`ifdef VVDIV_REM_EN
            r         <= '0;
`endif
            dz        <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg <= a;
                    x_reg <= x;
                    quo   <= '0;
                    rem   <= '0;
                    cnt   <= CW'(INT_SIZE);
                    state <= BUSY;
                end
                BUSY: begin
                    a_reg <= a_nxt;
                    quo   <= quo_nxt;
                    rem   <= rem_nxt;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        q         <= quo_nxt;
`ifdef VVDIV_REM_EN
                        r         <= rem_nxt;
`endif
                        dz        <= zero;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vvdiv.sv
// tb_vvdiv: directed-vector bench for vvdiv with an arithmetic reference model.
module tb_vvdiv;
    typedef logic [15:0][15:0] vec_t;
    logic clock = 0, resetn = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid;
    vec_t a = '0, x = '0, q;
`ifdef VVDIV_REM_EN
    vec_t r;
`endif
    logic [15:0] dz;
    vec_t eq, er;
    logic [15:0] edz;
    logic expv = 0;
    int n_chk = 0, n_fail = 0;

    vvdiv #(.VECTOR_SIZE(16), .INT_SIZE(16)) dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .x(x), .out_valid(out_valid), .out_ready(out_ready), .q(q),
`ifdef VVDIV_REM_EN
        .r(r),
`endif
        .dz(dz)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t rnd();
        vec_t v;
        for (int i = 0; i < 16; i++) v[i] = 16'($urandom);
        return v;
    endfunction

    // Reference results straight from integer division.
    task automatic model(input vec_t av, input vec_t xv);
        for (int i = 0; i < 16; i++) begin
            eq[i]  = xv[i] == 0 ? 16'hFFFF : av[i] / xv[i];
            er[i]  = xv[i] == 0 ? av[i] : av[i] % xv[i];
            edz[i] = xv[i] == 0;
        end
    endtask

    always @(negedge clock) begin
        if (resetn && out_valid) begin
            if (!expv) chk("unexpected_out_valid", out_valid, 0);
            else begin
                chk("q", q, eq);
`ifdef VVDIV_REM_EN
                chk("r", r, er);
`endif
                chk("dz", dz, edz);
                chk("in_ready_busy", in_ready, 0);
            end
        end
    end

    task automatic start(input vec_t av, input vec_t xv);
        @(negedge clock);
        chk("in_ready_idle", in_ready, 1);
        a = av; x = xv; in_valid = 1;
        model(av, xv);
        @(posedge clock); #1;
        in_valid = 0; a = rnd(); x = rnd();
        expv = 1;
    endtask

    task automatic finish_op(input int hold);
        int lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clock); #1; lat++; end
        chk("latency", lat, 16);
        repeat (hold) begin
            @(negedge clock);
            in_valid = 1; a = rnd(); x = rnd();
            chk("in_ready_done", in_ready, 0);
            chk("out_valid_hold", out_valid, 1);
        end
        @(negedge clock);
        in_valid = 0; out_ready = 1;
        @(posedge clock); #1;
        out_ready = 0; expv = 0;
        chk("out_valid_clr", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
        chk("q_kept", q, eq);
    endtask

    task automatic op(input vec_t av, input vec_t xv, input int hold);
        start(av, xv);
        finish_op(hold);
    endtask

    vec_t va, vx;
    initial begin
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q", q, 0);
        chk("rst_dz", dz, 0);
        @(negedge clock); resetn = 1;

        va = '0; vx = '1; for (int i = 0; i < 16; i++) vx[i] = 16'd1;
        va[0] = 100; vx[0] = 7;
        op(va, vx, 0);
        chk("lit_q0", q[0], 14);
`ifdef VVDIV_REM_EN
        chk("lit_r0", r[0], 2);
`endif
        chk("lit_dz", dz, 0);

        for (int i = 0; i < 16; i++) begin va[i] = 0; vx[i] = 1; end
        va[3] = 5; vx[3] = 0; va[4] = 9; vx[4] = 3;
        op(va, vx, 10);
        chk("lit_q3", q[3], 16'hFFFF);
        chk("lit_q4", q[4], 3);
`ifdef VVDIV_REM_EN
        chk("lit_r3", r[3], 5);
        chk("lit_r4", r[4], 0);
`endif
        chk("lit_dz34", dz, 16'h0008);

        for (int i = 0; i < 16; i++) begin va[i] = 0; vx[i] = 1; end
        va[0] = 65535; vx[0] = 1; va[1] = 3; vx[1] = 65535;
        op(va, vx, 2);
        chk("lit_q0_max", q[0], 65535);
        chk("lit_q1_zero", q[1], 0);
`ifdef VVDIV_REM_EN
        chk("lit_r1", r[1], 3);
`endif

        for (int i = 0; i < 16; i++) begin va[i] = 16'(i * 4099 + 17); vx[i] = 16'(i * 37); end
        op(va, vx, 1);
        chk("lit_q0_mix", q[0], 16'hFFFF);
        chk("lit_q1_mix", q[1], 111);

        for (int i = 0; i < 16; i++) begin va[i] = 16'(65535 - i * 1000); vx[i] = 16'(i + 2); end
        op(va, vx, 0);

        // Abort in the 5th busy cycle.
        for (int i = 0; i < 16; i++) begin va[i] = 0; vx[i] = 1; end
        va[0] = 100; vx[0] = 7;
        start(va, vx);
        repeat (4) @(posedge clock);
        #1 resetn = 0; expv = 0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_q", q, 0);
        chk("abort_dz", dz, 0);
`ifdef VVDIV_REM_EN
        chk("abort_r", r, 0);
`endif
        @(negedge clock); resetn = 1;
        repeat (20) @(negedge clock);
        chk("abort_no_result", out_valid, 0);
        op(va, vx, 0);
        chk("lit_q0_again", q[0], 14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/vvdiv.md
VVDIV -- requirements
Module: vvdiv

Interface
REQ-001 Parameter VECTOR_SIZE, default 16, number of lanes.
REQ-002 Parameter INT_SIZE, default 16, lane width in bits, unsigned.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand vectors a, x present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  [VECTOR_SIZE-1:0][INT_SIZE-1:0]  dividend vector.
REQ-008 x  input  [VECTOR_SIZE-1:0][INT_SIZE-1:0]  divisor vector.
REQ-009 out_valid  output  1  result vectors valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 q  output  [VECTOR_SIZE-1:0][INT_SIZE-1:0]  per-lane quotient a[i]/x[i].
REQ-012 r  output  [VECTOR_SIZE-1:0][INT_SIZE-1:0]  per-lane remainder a[i]%x[i]; present only with VVDIV_REM_EN.
REQ-013 dz  output  [VECTOR_SIZE-1:0]  per-lane divide-by-zero flag.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-015 in_ready SHALL be 1 in IDLE only and 0 in BUSY and DONE.
REQ-016 Accept: in_valid&&in_ready at a rising edge SHALL latch a and x into internal registers and move IDLE->BUSY; in_valid outside IDLE SHALL be ignored.
REQ-017 BUSY SHALL run unsigned restoring division on all lanes in parallel, one quotient bit per lane per cycle, MSB first, for exactly INT_SIZE cycles, tracked by a down-counter.
REQ-018 The edge ending the last BUSY cycle SHALL move BUSY->DONE, update q, r, dz, and set out_valid=1; out_valid is first high INT_SIZE edges after the accept edge.
REQ-019 In DONE, q, r, dz and out_valid SHALL stay stable until out_valid&&out_ready at a rising edge.
REQ-020 On that edge the FSM SHALL move DONE->IDLE and clear out_valid; q, r and dz SHALL keep their values; in_ready is high in the following cycle. No overlap of consecutive operations.
REQ-021 Lane with x[i]==0: q[i] SHALL be all ones, r[i] SHALL equal a[i], dz[i] SHALL be 1; other lanes are unaffected.
REQ-022 Lane with x[i]!=0: dz[i]=0, q[i]*x[i]+r[i]==a[i], r[i]<x[i], all modulo-free at INT_SIZE bits.
REQ-023 Changes on a and x after the accept edge SHALL NOT affect the result.

Reset
REQ-024 resetn low SHALL immediately force IDLE, in_ready=1 (combinational from state), out_valid=0, q=0, r=0, dz=0, and clear the counter and the operand registers.
REQ-025 Reset asserted in BUSY or DONE SHALL abort the operation; no result is produced for it.

Configuration
REQ-026 Macro VVDIV_REM_EN defined: port r is present and driven per REQ-011/021/022.
REQ-027 VVDIV_REM_EN undefined: port r and its output register are absent; q, dz, timing and handshake are unchanged.

Verification
REQ-028 Accept a[0]=100, x[0]=7, other lanes a=0 x=1 -> q[0]=14, r[0]=2, dz=0, out_valid high exactly 16 edges after accept.
REQ-029 a[3]=5, x[3]=0, a[4]=9, x[4]=3 -> q[3]=16'hFFFF, r[3]=5, dz[3]=1, q[4]=3, r[4]=0, dz[4]=0.
REQ-030 Lane 0 a=65535 x=1, lane 1 a=3 x=65535 -> q[0]=65535 r[0]=0, q[1]=0 r[1]=3.
REQ-031 out_ready held 0 for 10 cycles in DONE, in_valid=1 with new operands -> q/r/dz stable, in_ready=0, new operands not accepted; after out_ready=1 for one edge, in_ready=1 next cycle.
REQ-032 resetn pulsed low in the 5th BUSY cycle -> out_valid=0, q=r=dz=0, in_ready=1 during reset; next accept yields a correct result 16 edges later.
REQ-033 Build without VVDIV_REM_EN, repeat REQ-028 -> q[0]=14, same latency, no r port.
